// File: rtl/fpalu_pkg.sv
// Shared FP-ALU definitions: opcode encodings, default pipeline latencies,
// the opcode-to-latency mapping and the sequencer state encoding.
package fpalu_pkg;

    localparam int FOP_W = 5;

    localparam logic [FOP_W-1:0] FOPADD   = 5'd0;
    localparam logic [FOP_W-1:0] FOPSUB   = 5'd1;
    localparam logic [FOP_W-1:0] FOPMUL   = 5'd2;
    localparam logic [FOP_W-1:0] FOPDIV   = 5'd3;
    localparam logic [FOP_W-1:0] FOPSQRT  = 5'd4;
    localparam logic [FOP_W-1:0] FOPABS   = 5'd5;
    localparam logic [FOP_W-1:0] FOPNEG   = 5'd6;
    localparam logic [FOP_W-1:0] FOPCEQ   = 5'd7;
    localparam logic [FOP_W-1:0] FOPCLT   = 5'd8;
    localparam logic [FOP_W-1:0] FOPCLE   = 5'd9;
    localparam logic [FOP_W-1:0] FOPCVTSW = 5'd10;
    localparam logic [FOP_W-1:0] FOPCVTWS = 5'd11;

    localparam int unsigned LAT_ADD_DEF  = 7;
    localparam int unsigned LAT_MUL_DEF  = 5;
    localparam int unsigned LAT_DIV_DEF  = 6;
    localparam int unsigned LAT_SQRT_DEF = 16;
    localparam int unsigned LAT_CMP_DEF  = 1;
    localparam int unsigned LAT_CVT_DEF  = 6;
    localparam int unsigned LAT_COMB_DEF = 1;
    localparam int unsigned CNT_W_DEF    = 5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic fop_is_cmp(input logic [FOP_W-1:0] op);
        return (op == FOPCEQ) || (op == FOPCLT) || (op == FOPCLE);
    endfunction

    // Unlisted opcodes fall through to the combinational latency.
    function automatic int unsigned fop_lat(
        input logic [FOP_W-1:0] op,
        input int unsigned l_add, l_mul, l_div, l_sqrt, l_cmp, l_cvt, l_comb
    );
        int unsigned lat;
        case (op)
            FOPADD, FOPSUB:                 lat = l_add;
            FOPMUL:                         lat = l_mul;
            FOPDIV:                         lat = l_div;
            FOPSQRT:                        lat = l_sqrt;
            FOPCEQ, FOPCLT, FOPCLE:         lat = l_cmp;
            FOPCVTSW, FOPCVTWS:             lat = l_cvt;
            default:                        lat = l_comb;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpalu_lat_lut.sv
// Opcode to ALU pipeline latency lookup, sized to the sequencer counter.
module fpalu_lat_lut
    import fpalu_pkg::*;
#(
    parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
    parameter int unsigned LAT_MUL  = LAT_MUL_DEF,
    parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
    parameter int unsigned LAT_SQRT = LAT_SQRT_DEF,
    parameter int unsigned LAT_CMP  = LAT_CMP_DEF,
    parameter int unsigned LAT_CVT  = LAT_CVT_DEF,
    parameter int unsigned LAT_COMB = LAT_COMB_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic [FOP_W-1:0] icontrol,
    output logic [CNT_W-1:0] olat
);

    assign olat = CNT_W'(fop_lat(icontrol, LAT_ADD, LAT_MUL, LAT_DIV, LAT_SQRT,
                                 LAT_CMP, LAT_CVT, LAT_COMB));

endmodule

// File: rtl/fpalu_seq.sv
// Issue/sequencing stage in front of the FP ALU: holds operands stable,
// waits out the opcode latency, captures result/flags, tracks cond and sticky bits.
module fpalu_seq
    import fpalu_pkg::*;
#(
    parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
    parameter int unsigned LAT_MUL  = LAT_MUL_DEF,
    parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
    parameter int unsigned LAT_SQRT = LAT_SQRT_DEF,
    parameter int unsigned LAT_CMP  = LAT_CMP_DEF,
    parameter int unsigned LAT_CVT  = LAT_CVT_DEF,
    parameter int unsigned LAT_COMB = LAT_COMB_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              iclock,
    input  logic              ireset_n,
    input  logic              istart,
    input  logic [FOP_W-1:0]  icontrol,
    input  logic [31:0]       idataa,
    input  logic [31:0]       idatab,
    output logic              oready,
    output logic              ovalid,
    input  logic              iack,
    output logic [31:0]       oresult,
    output logic              onan,
    output logic              ozero,
    output logic              ooverflow,
    output logic              ounderflow,
    output logic              ocond,
    output logic [2:0]        osticky,
    input  logic              iclear_sticky,
    output logic [31:0]       oalu_dataa,
    output logic [31:0]       oalu_datab,
    output logic [FOP_W-1:0]  oalu_control,
    input  logic [31:0]       ialu_result,
    input  logic              ialu_nan,
    input  logic              ialu_zero,
    input  logic              ialu_overflow,
    input  logic              ialu_underflow,
    input  logic              ialu_comp
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, lat;
    logic             accept, capture;
    logic [2:0]       sticky_base;

    fpalu_lat_lut #(
        .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .LAT_SQRT(LAT_SQRT),
        .LAT_CMP(LAT_CMP), .LAT_CVT(LAT_CVT), .LAT_COMB(LAT_COMB), .CNT_W(CNT_W)
    ) u_lat_lut (
        .icontrol(icontrol),
        .olat(lat)
    );

    always_comb begin
        state_nx = state;
        oready   = 1'b0;
        ovalid   = 1'b0;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                oready = 1'b1;
                if (istart) begin
                    accept   = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                ovalid = 1'b1;
                if (iack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A clear coinciding with a capture wipes the old flags before the new ones OR in.
    assign sticky_base = iclear_sticky ? 3'b000 : osticky;

    always_ff @(posedge iclock) begin
        if (!ireset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            oresult      <= '0;
            onan         <= 1'b0;
            ozero        <= 1'b0;
            ooverflow    <= 1'b0;
            ounderflow   <= 1'b0;
            ocond        <= 1'b0;
            osticky      <= 3'b000;
            oalu_dataa   <= '0;
            oalu_datab   <= '0;
            oalu_control <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt          <= lat;
                oalu_dataa   <= idataa;
                oalu_datab   <= idatab;
                oalu_control <= icontrol;
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                oresult    <= ialu_result;
                onan       <= ialu_nan;
                ozero      <= ialu_zero;
                ooverflow  <= ialu_overflow;
                ounderflow <= ialu_underflow;
                if (fop_is_cmp(oalu_control)) ocond <= ialu_comp;
                osticky <= sticky_base | {ialu_nan, ialu_overflow, ialu_underflow};
            end else if (iclear_sticky) begin
                osticky <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_fpalu_seq.sv
// Randomised self-checking bench for fpalu_seq; the ALU is a stub that presents
// random values every cycle and the intended result only on the capture cycle.
module tb_fpalu_seq;
    import fpalu_pkg::*;

    logic        iclock = 1'b0;
    logic        ireset_n, istart, iack, iclear_sticky;
    logic [4:0]  icontrol, oalu_control;
    logic [31:0] idataa, idatab, oresult, oalu_dataa, oalu_datab, ialu_result;
    logic        oready, ovalid, onan, ozero, ooverflow, ounderflow, ocond;
    logic [2:0]  osticky;
    logic        ialu_nan, ialu_zero, ialu_overflow, ialu_underflow, ialu_comp;

    int checks = 0;
    int passed = 0;
    bit       exp_cond;
    bit [2:0] exp_sticky;

    always #5 iclock = ~iclock;

    fpalu_seq dut (
        .iclock(iclock), .ireset_n(ireset_n), .istart(istart), .icontrol(icontrol),
        .idataa(idataa), .idatab(idatab), .oready(oready), .ovalid(ovalid), .iack(iack),
        .oresult(oresult), .onan(onan), .ozero(ozero), .ooverflow(ooverflow),
        .ounderflow(ounderflow), .ocond(ocond), .osticky(osticky),
        .iclear_sticky(iclear_sticky), .oalu_dataa(oalu_dataa), .oalu_datab(oalu_datab),
        .oalu_control(oalu_control), .ialu_result(ialu_result), .ialu_nan(ialu_nan),
        .ialu_zero(ialu_zero), .ialu_overflow(ialu_overflow),
        .ialu_underflow(ialu_underflow), .ialu_comp(ialu_comp)
    );

    function automatic int ref_lat(input logic [4:0] op);
        if (op == FOPADD || op == FOPSUB) return 7;
        if (op == FOPMUL) return 5;
        if (op == FOPDIV) return 6;
        if (op == FOPSQRT) return 16;
        if (op == FOPCEQ || op == FOPCLT || op == FOPCLE) return 1;
        if (op == FOPCVTSW || op == FOPCVTWS) return 6;
        return 1;
    endfunction

    function automatic bit ref_cmp(input logic [4:0] op);
        return op == FOPCEQ || op == FOPCLT || op == FOPCLE;
    endfunction

    task automatic alu_noise();
        ialu_result = $urandom;
        {ialu_nan, ialu_zero, ialu_overflow, ialu_underflow, ialu_comp} = 5'($urandom);
    endtask

    // Drives one request end to end and reports what was observed; the
    // reference model (exp_cond/exp_sticky) is advanced from the request itself.
    task automatic run_op(
        input  logic [4:0]  op, input logic [31:0] a, input logic [31:0] b,
        input  logic [31:0] res, input logic [3:0] flg, input logic comp,
        input  bit clr_cap, input int hold, input bit noisy,
        output int lat_obs, output logic [31:0] r_obs, output logic [3:0] f_obs,
        output logic c_obs, output logic [2:0] s_obs,
        output bit stable, output bit held, output bit rdy_after
    );
        int guard = 0;
        while (!oready && guard < 50) begin @(posedge iclock); #1; guard++; end
        istart = 1'b1; icontrol = op; idataa = a; idatab = b;
        @(posedge iclock); #1;
        istart = 1'b0;
        stable = 1'b1;
        lat_obs = -1;
        for (int j = 1; j <= 40 && lat_obs < 0; j++) begin
            if (j == ref_lat(op)) begin
                ialu_result = res;
                {ialu_nan, ialu_zero, ialu_overflow, ialu_underflow} = flg;
                ialu_comp = comp;
                iclear_sticky = clr_cap;
            end else begin
                alu_noise();
                iclear_sticky = 1'b0;
            end
            if (noisy) begin
                idataa = $urandom; idatab = $urandom; icontrol = 5'($urandom);
                istart = 1'($urandom); iack = 1'($urandom);
            end
            @(posedge iclock); #1;
            if (oalu_dataa !== a || oalu_datab !== b || oalu_control !== op) stable = 1'b0;
            if (ovalid) lat_obs = j;
        end
        istart = 1'b0; iack = 1'b0; iclear_sticky = 1'b0;
        alu_noise();
        if (ref_cmp(op)) exp_cond = comp;
        exp_sticky = (clr_cap ? 3'b000 : exp_sticky) | {flg[3], flg[1], flg[0]};
        r_obs = oresult;
        f_obs = {onan, ozero, ooverflow, ounderflow};
        c_obs = ocond;
        s_obs = osticky;
        held = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (noisy) begin idataa = $urandom; idatab = $urandom; istart = 1'b1; end
            alu_noise();
            @(posedge iclock); #1;
            if (!ovalid || oready || oresult !== r_obs || oalu_dataa !== a ||
                oalu_datab !== b || {onan, ozero, ooverflow, ounderflow} !== f_obs) held = 1'b0;
        end
        istart = 1'b0;
        iack = 1'b1;
        @(posedge iclock); #1;
        iack = 1'b0;
        rdy_after = oready && !ovalid;
    endtask

    int          lat_o;
    logic [31:0] r_o;
    logic [3:0]  f_o;
    logic        c_o;
    logic [2:0]  s_o;
    bit          stab_o, held_o, rdy_o;

    task automatic test_reset();
        ireset_n = 1'b0; istart = 1'b0; iack = 1'b0; iclear_sticky = 1'b0;
        icontrol = '0; idataa = '0; idatab = '0;
        alu_noise();
        repeat (2) @(posedge iclock);
        #1;
        ireset_n = 1'b1;
        exp_cond = 1'b0; exp_sticky = 3'b000;
        checks++;
        if ({oready, ovalid} !== 2'b10) $display("FAIL reset_hs: got %b want 10", {oready, ovalid});
        else passed++;
        checks++;
        if ({oresult, oalu_dataa, oalu_datab, oalu_control} !== '0)
            $display("FAIL reset_data: got %h %h %h %h want 0", oresult, oalu_dataa, oalu_datab, oalu_control);
        else passed++;
        checks++;
        if ({onan, ozero, ooverflow, ounderflow, ocond, osticky} !== 8'b0)
            $display("FAIL reset_flags: got %b want 0", {onan, ozero, ooverflow, ounderflow, ocond, osticky});
        else passed++;
    endtask

    task automatic test_add();
        run_op(FOPADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0, 1'b0, 0, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (lat_o !== 7) $display("FAIL add_lat: got %0d want 7", lat_o); else passed++;
        checks++;
        if (r_o !== 32'h40400000) $display("FAIL add_result: got %h want 40400000", r_o); else passed++;
        checks++;
        if (f_o !== 4'b0000) $display("FAIL add_flags: got %b want 0000", f_o); else passed++;
        checks++;
        if (!rdy_o) $display("FAIL add_ready_after_ack: got 0 want 1"); else passed++;
    endtask

    task automatic test_cmp();
        run_op(FOPCLT, 32'h3F800000, 32'h40000000, 32'h0, 4'b0000, 1'b1, 1'b0, 0, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (lat_o !== 1) $display("FAIL clt_lat: got %0d want 1", lat_o); else passed++;
        checks++;
        if (c_o !== 1'b1) $display("FAIL clt_cond: got %b want 1", c_o); else passed++;
        run_op(FOPMUL, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 1'b0, 1'b0, 0, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (c_o !== exp_cond || c_o !== 1'b1) $display("FAIL mul_keeps_cond: got %b want 1", c_o); else passed++;
        checks++;
        if (lat_o !== 5) $display("FAIL mul_lat: got %0d want 5", lat_o); else passed++;
    endtask

    task automatic test_sticky();
        run_op(FOPMUL, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0010, 1'b0, 1'b0, 0, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (f_o !== 4'b0010) $display("FAIL ovf_flags: got %b want 0010", f_o); else passed++;
        checks++;
        if (s_o !== 3'b010) $display("FAIL ovf_sticky: got %b want 010", s_o); else passed++;
        run_op(FOPADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b0, 1'b0, 0, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (s_o !== 3'b010) $display("FAIL clean_add_sticky: got %b want 010", s_o); else passed++;
        iclear_sticky = 1'b1;
        @(posedge iclock); #1;
        iclear_sticky = 1'b0;
        exp_sticky = 3'b000;
        checks++;
        if (osticky !== 3'b000) $display("FAIL clear_alone: got %b want 000", osticky); else passed++;
        run_op(FOPSUB, 32'h7FC00000, 32'h0, 32'h7FC00000, 4'b1000, 1'b0, 1'b0, 0, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (s_o !== 3'b100) $display("FAIL nan_sticky: got %b want 100", s_o); else passed++;
        run_op(FOPDIV, 32'h00800000, 32'h7F000000, 32'h0, 4'b0101, 1'b0, 1'b1, 0, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (s_o !== 3'b001) $display("FAIL clear_on_capture: got %b want 001", s_o); else passed++;
    endtask

    task automatic test_stability();
        run_op(FOPCVTSW, 32'h00000005, 32'h12345678, 32'h40A00000, 4'b0000, 1'b0, 1'b0, 4, 1'b1,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (!stab_o) $display("FAIL operand_stable: got unstable want stable"); else passed++;
        checks++;
        if (!held_o) $display("FAIL done_ignores_start: got changed want held"); else passed++;
        checks++;
        if (lat_o !== 6) $display("FAIL cvt_lat: got %0d want 6", lat_o); else passed++;
    endtask

    task automatic test_hold();
        run_op(FOPABS, 32'hC0000000, 32'h0, 32'h40000000, 4'b0000, 1'b0, 1'b0, 10, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (!held_o || r_o !== 32'h40000000) $display("FAIL hold_10: held %b result %h want 1 40000000", held_o, r_o);
        else passed++;
        checks++;
        if (!rdy_o) $display("FAIL hold_ack_ready: got 0 want 1"); else passed++;
    endtask

    task automatic test_reset_abort();
        run_op(FOPMUL, 32'h1, 32'h1, 32'h1, 4'b0010, 1'b0, 1'b0, 0, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        istart = 1'b1; icontrol = FOPSQRT; idataa = 32'h41100000; idatab = 32'h0;
        @(posedge iclock); #1;
        istart = 1'b0;
        for (int j = 1; j < 8; j++) begin alu_noise(); @(posedge iclock); #1; end
        ialu_result = 32'hFFFFFFFF;
        {ialu_nan, ialu_zero, ialu_overflow, ialu_underflow, ialu_comp} = 5'b11111;
        ireset_n = 1'b0;
        @(posedge iclock); #1;
        ireset_n = 1'b1;
        exp_cond = 1'b0; exp_sticky = 3'b000;
        checks++;
        if ({oready, ovalid} !== 2'b10) $display("FAIL abort_hs: got %b want 10", {oready, ovalid}); else passed++;
        checks++;
        if ({oresult, oalu_dataa, oalu_datab, oalu_control, onan, ozero, ooverflow, ounderflow, ocond, osticky} !== '0)
            $display("FAIL abort_outputs: got %h %h %b want all 0", oresult, oalu_dataa, {onan, ozero, ooverflow, ounderflow, ocond, osticky});
        else passed++;
        run_op(FOPNEG, 32'h3F800000, 32'h0, 32'hBF800000, 4'b0000, 1'b0, 1'b0, 0, 1'b0,
               lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
        checks++;
        if (lat_o !== 1 || r_o !== 32'hBF800000) $display("FAIL neg_after_abort: lat %0d result %h want 1 BF800000", lat_o, r_o);
        else passed++;
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] a, b, res;
        logic [3:0]  flg;
        logic        comp;
        for (int n = 0; n < 24; n++) begin
            op = 5'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            res = $urandom; flg = 4'($urandom); comp = 1'($urandom);
            if (op > FOPCVTWS) begin res = '0; flg = '0; comp = 1'b0; end
            run_op(op, a, b, res, flg, comp, 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                   lat_o, r_o, f_o, c_o, s_o, stab_o, held_o, rdy_o);
            checks++;
            if (lat_o !== ref_lat(op) || r_o !== res || f_o !== flg)
                $display("FAIL rand_capture op=%0d: lat %0d res %h flg %b want %0d %h %b",
                         op, lat_o, r_o, f_o, ref_lat(op), res, flg);
            else passed++;
            checks++;
            if (c_o !== exp_cond || s_o !== exp_sticky)
                $display("FAIL rand_cond_sticky op=%0d: got %b %b want %b %b", op, c_o, s_o, exp_cond, exp_sticky);
            else passed++;
            checks++;
            if (!stab_o || !held_o || !rdy_o)
                $display("FAIL rand_handshake op=%0d: stable %b held %b ready %b want 111", op, stab_o, held_o, rdy_o);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp();
        test_sticky();
        test_stability();
        test_hold();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fpalu_seq.md
# fpalu_seq

Issue/sequencing stage directly upstream of the floating-point ALU. It accepts one FP operation at a time through a ready/valid handshake and holds the operands and opcode stable on the ALU inputs. It counts the opcode-specific pipeline latency, then captures the ALU result and flags into registers. It also maintains the FP condition bit and sticky exception flags.

## Interface
Parameters:
- LAT_ADD, 7: cycles the ALU takes for FOPADD/FOPSUB.
- LAT_MUL, 5: cycles for FOPMUL.
- LAT_DIV, 6: cycles for FOPDIV.
- LAT_SQRT, 16: cycles for FOPSQRT.
- LAT_CMP, 1: cycles for FOPCEQ/FOPCLT/FOPCLE.
- LAT_CVT, 6: cycles for FOPCVTSW/FOPCVTWS.
- LAT_COMB, 1: cycles for FOPABS, FOPNEG and any unlisted opcode.
- CNT_W, 5: width of the latency counter. Every LAT_* must be in the range 1..2^CNT_W-1.

Ports:
- iclock, in, 1: sole clock; all logic is on the rising edge.
- ireset_n, in, 1: reset, synchronous and active-low.
- istart, in, 1: request valid.
- icontrol, in, 5: FP opcode, using the FOP* codes.
- idataa, idatab, in, 32: operands.
- oready, out, 1: block can accept a request.
- ovalid, out, 1: captured result is available.
- iack, in, 1: consumer has taken the result.
- oresult, out, 32: captured ALU result.
- onan, ozero, ooverflow, ounderflow, out, 1 each: captured ALU flags.
- ocond, out, 1: FP condition bit.
- osticky, out, 3: sticky flags {nan, overflow, underflow}.
- iclear_sticky, in, 1: clears osticky.
- oalu_dataa, oalu_datab, out, 32: operands driven to the ALU.
- oalu_control, out, 5: opcode driven to the ALU.
- ialu_result, in, 32: ALU result.
- ialu_nan, ialu_zero, ialu_overflow, ialu_underflow, ialu_comp, in, 1 each: ALU flags and compare result.

## Operation
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - oready=1.
  - On istart=1, latch icontrol, idataa and idatab into operand registers.
  - Load the counter with LAT(icontrol) and go to BUSY.
- BUSY:
  - oready=0.
  - The counter decrements every cycle.
  - When the counter is 1, on that edge capture ialu_result and the four ALU flags into the output registers, then go to DONE.
  - On a compare opcode, the same edge also loads ialu_comp into ocond.
  - Non-compare opcodes leave ocond unchanged.
- DONE:
  - ovalid=1 and all outputs are held.
  - On iack=1, go to IDLE.
  - istart is ignored in DONE; a new request is accepted only in a later IDLE cycle.
- oalu_* always reflect the operand registers, which change only on request acceptance. The ALU inputs are therefore stable for the whole of BUSY and DONE.
- Sticky flags:
  - On each capture, osticky |= {ialu_nan, ialu_overflow, ialu_underflow}.
  - iclear_sticky in a cycle with no capture sets osticky to 0.
  - If a capture and iclear_sticky occur in the same cycle, osticky takes exactly the new flags (clear first, then OR).
- Opcodes not in the FOP* set use LAT_COMB and capture whatever the ALU presents, which is all zeros.

## Timing
- Reset (ireset_n=0 at an edge):
  - The FSM goes to IDLE and the counter to 0.
  - oresult, oalu_dataa and oalu_datab go to 0, and oalu_control goes to 0.
  - All 1-bit flag outputs go to 0, ocond to 0 and osticky to 0.
  - As a result oready=1 and ovalid=0.
- Reset in BUSY or DONE aborts the operation. The result is discarded, no capture happens and osticky is cleared.
- Latency: if the request is accepted at edge k, capture happens at edge k+LAT. ovalid is high from cycle k+LAT through the cycle in which iack is sampled high.
- Back-to-back throughput is one op per LAT+2 cycles (accept, LAT, ack, idle).
- iack sampled high while in IDLE or BUSY has no effect.
- oready and ovalid are never high at the same time.

## Structure
- LAT defaults and the opcode-to-latency mapping belong in the shared parameters header next to the FOP* codes.
- Define a localparam enum for the FSM states.
- Implement the opcode-to-latency mapping as one combinational function or sub-module, fpalu_lat_lut (icontrol -> olat[CNT_W-1:0]).
- The top of this block instantiates FPALU alongside itself in the FP datapath; the two are not nested.

## Test plan
- FOPADD, idataa=32'h3F800000, idatab=32'h40000000 (ALU model: 7-cycle add) -> ovalid rises exactly 7 cycles after acceptance; oresult=32'h40400000, all flags 0.
- FOPCLT, a=32'h3F800000 (1.0), b=32'h40000000 (2.0), with LAT_CMP=1 -> ocond=1 one cycle after acceptance. A following FOPMUL leaves ocond=1.
- FOPMUL, 32'h7F000000 × 32'h7F000000 -> ooverflow=1 and osticky=3'b010. A following clean add keeps osticky=3'b010. Pulse iclear_sticky alone -> 3'b000. Pulse iclear_sticky on a capture cycle carrying underflow -> 3'b001.
- Operand stability: change idataa/idatab every cycle while BUSY or DONE -> oalu_dataa/oalu_datab stay at the latched values. istart pulsed while in DONE is not accepted (oready=0).
- Hold iack=0 for 10 cycles after ovalid -> oresult is held. Assert iack -> IDLE with oready=1 on the next cycle.
- Assert ireset_n=0 mid-FOPSQRT (cycle 8 of 16) -> the next cycle shows IDLE, ovalid=0 and all outputs 0. A new FOPNEG of 32'h3F800000 then yields 32'hBF800000 one cycle after acceptance.
